tob_signal_engine: RTL and testbench
====================================

TOB_SIGNAL_ENGINE -- requirements
Module: tob_signal_engine

Interface
REQ-001 Parameter SPREAD_THRESH, default 32'd2, max ask-minus-bid spread (price ticks) that permits an order.
REQ-002 Parameter MAX_QTY, default 32'd100, per-order quantity cap.
REQ-003 Parameter COOLDOWN, default 16'd4, idle cycles enforced after each accepted order.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  async active-low reset.
- best_bid_price  in  32  top-of-book bid price; 0 = empty.
- best_bid_qty  in  32  top-of-book bid quantity.
- best_ask_price  in  32  top-of-book ask price; 32'hFFFFFFFF = empty.
- best_ask_qty  in  32  top-of-book ask quantity.
- tob_valid  in  1  top-of-book inputs are meaningful.
- order_ready  in  1  downstream accepts order this cycle.
- order_valid  out  1  order payload valid.
- order_side  out  8  0 = Buy, 1 = Sell.
- order_price  out  32  order limit price.
- order_qty  out  32  order quantity.
- busy  out  1  high in any state other than IDLE.
- order_count  out  32  orders accepted (valid & ready).
- reject_count  out  32  evaluations that produced no order.
- crossed_count  out  32  evaluations that saw a crossed book.

Function
REQ-006 FSM states: IDLE, EVAL, SEND, COOL.
REQ-007 IDLE: when tob_valid=1, capture all four TOB inputs into snapshot registers and go to EVAL on that edge; otherwise stay in IDLE.
REQ-008 EVAL (one cycle), checks in priority order:
- (a) Empty: snapshot bid=0 or ask=FFFFFFFF -> reject_count+1, go to IDLE.
- (b) Crossed: bid >= ask -> crossed_count+1 and reject_count+1, go to IDLE.
- (c) Wide: (ask - bid) > SPREAD_THRESH, 32-bit unsigned and computed only when not crossed -> reject_count+1, go to IDLE.
- (d) Otherwise, form an order as in REQ-009.
REQ-009 Order formation:
- If bid_qty >= ask_qty: side=0 (Buy), price=ask, qty=min(ask_qty, MAX_QTY).
- Else: side=1 (Sell), price=bid, qty=min(bid_qty, MAX_QTY).
- If the resulting qty = 0: reject_count+1, go to IDLE.
- Else: register the payload, set order_valid=1, go to SEND.
REQ-010 Latency: tob_valid sampled at edge T; order_valid is high after edge T+1; two cycles from input to order.
REQ-011 SEND: order_valid and the payload hold stable until order_ready=1 is sampled. On that edge:
- order_valid goes to 0 and order_count increments.
- Go to COOL, or to IDLE if COOLDOWN=0.
REQ-012 COOL: a 16-bit down-counter loaded with COOLDOWN-1 on SEND exit. Return to IDLE on the edge where the counter is 0. tob_valid is ignored in COOL.
REQ-013 TOB inputs changing during EVAL, SEND or COOL have no effect on the snapshot or payload.
REQ-014 order_ready while order_valid=0 is ignored.
REQ-015 All counters are 32-bit and wrap from FFFFFFFF to 0.
REQ-016 At most one counter-incrementing event occurs per counter per cycle.
REQ-017 busy = (state != IDLE), registered consistently with the state register.

Reset
REQ-018 rstn low forces, asynchronously:
- state to IDLE; order_valid, busy, order_side, order_price, order_qty to 0.
- all three counters, the cooldown counter and the snapshot registers to 0.
REQ-019 Reset asserted mid-SEND drops order_valid immediately; the pending order is discarded and not counted.
REQ-020 After rstn rises, the first tob_valid=1 sampled in IDLE starts a fresh evaluation.

Verification
REQ-021 Buy order: bid=100/50, ask=101/30, tob_valid=1, order_ready=1 -> order_valid high 2 cycles after sample; side=0, price=101, qty=30; order_count=1; then 4 COOL cycles; busy high throughout.
REQ-022 Cap and hold: bid=100/500, ask=102/10, order_ready=0 for 5 cycles then 1 -> side=0, price=102, qty=10. Repeat with bid_qty=10, ask_qty=500 -> side=1, price=100, qty=10. Payload stable while order_ready=0.
REQ-023 Rejects:
- bid=0 -> reject_count+1.
- bid=105, ask=103 -> crossed_count+1, reject_count+1.
- bid=100, ask=110 -> reject_count+1.
- No order_valid in any case.
REQ-024 Quantity cap: bid=100/1000, ask=101/800 -> qty=100 (MAX_QTY).
REQ-025 Reset in SEND: drive rstn low while order_valid=1 -> all outputs 0 at once, order_count=0; after release, a new valid TOB produces an order normally.
REQ-026 Wrap: force order_count to FFFFFFFF, complete one order -> order_count=0.

Source files
------------

// File: rtl/tob_signal_engine.sv
// tob_signal_engine: top-of-book signal engine.
// It captures a top-of-book snapshot when tob_valid is high. It then checks
// the snapshot for an empty, crossed or wide book. If the book is good it
// emits one order, holds it until the downstream accepts it, and then waits
// a fixed number of cooldown cycles before it looks at the book again.
// Ports:
//   clk, rstn              clock, async active-low reset
//   best_bid_price/_qty    top-of-book bid (price 0 = empty)
//   best_ask_price/_qty    top-of-book ask (price FFFFFFFF = empty)
//   tob_valid              book inputs meaningful this cycle
//   order_ready            downstream accepts the order this cycle
//   order_valid/_side/_price/_qty  registered order payload (side 0=Buy, 1=Sell)
//   busy                   high whenever the FSM is not idle
//   order_count/reject_count/crossed_count  32-bit wrapping statistics
module tob_signal_engine #(
  parameter logic [31:0] SPREAD_THRESH = 32'd2,
  parameter logic [31:0] MAX_QTY       = 32'd100,
  parameter logic [15:0] COOLDOWN      = 16'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] best_bid_price,
  input  logic [31:0] best_bid_qty,
  input  logic [31:0] best_ask_price,
  input  logic [31:0] best_ask_qty,
  input  logic        tob_valid,
  input  logic        order_ready,
  output logic        order_valid,
  output logic [7:0]  order_side,
  output logic [31:0] order_price,
  output logic [31:0] order_qty,
  output logic        busy,
  output logic [31:0] order_count,
  output logic [31:0] reject_count,
  output logic [31:0] crossed_count
);

  localparam int unsigned PW = 32;
  localparam int unsigned QW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned TW = 16;

  localparam logic [PW-1:0] ASK_EMPTY = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_SEND,
    ST_COOL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_snap_bid, w_snap_bid_nxt;
  logic [QW-1:0] r_snap_bid_qty, w_snap_bid_qty_nxt;
  logic [PW-1:0] r_snap_ask, w_snap_ask_nxt;
  logic [QW-1:0] r_snap_ask_qty, w_snap_ask_qty_nxt;
  logic          r_valid, w_valid_nxt;
  logic [SW-1:0] r_side, w_side_nxt;
  logic [PW-1:0] r_price, w_price_nxt;
  logic [QW-1:0] r_qty, w_qty_nxt;
  logic          r_busy, w_busy_nxt;
  logic [CW-1:0] r_order_count, w_order_count_nxt;
  logic [CW-1:0] r_reject_count, w_reject_count_nxt;
  logic [CW-1:0] r_crossed_count, w_crossed_count_nxt;
  logic [TW-1:0] r_cool_cnt, w_cool_cnt_nxt;

  // Evaluation terms derived from the snapshot
  logic          w_empty;
  logic          w_crossed;
  logic [PW-1:0] w_spread;
  logic          w_wide;
  logic          w_buy;
  logic [QW-1:0] w_raw_qty;
  logic [QW-1:0] w_cap_qty;

  assign w_empty   = (r_snap_bid == '0) || (r_snap_ask == ASK_EMPTY);
  assign w_crossed = (r_snap_bid >= r_snap_ask);
  // The spread is only meaningful when the book is not crossed. w_wide is masked accordingly.
  assign w_spread  = r_snap_ask - r_snap_bid;
  assign w_wide    = !w_crossed && (w_spread > SPREAD_THRESH);
  // Trade against the thinner side: buy at the ask if the bid is at least as deep
  assign w_buy     = (r_snap_bid_qty >= r_snap_ask_qty);
  assign w_raw_qty = w_buy ? r_snap_ask_qty : r_snap_bid_qty;
  assign w_cap_qty = (w_raw_qty > MAX_QTY) ? MAX_QTY : w_raw_qty;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_snap_bid      <= '0;
      r_snap_bid_qty  <= '0;
      r_snap_ask      <= '0;
      r_snap_ask_qty  <= '0;
      r_valid         <= 1'b0;
      r_side          <= '0;
      r_price         <= '0;
      r_qty           <= '0;
      r_busy          <= 1'b0;
      r_order_count   <= '0;
      r_reject_count  <= '0;
      r_crossed_count <= '0;
      r_cool_cnt      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_snap_bid      <= w_snap_bid_nxt;
      r_snap_bid_qty  <= w_snap_bid_qty_nxt;
      r_snap_ask      <= w_snap_ask_nxt;
      r_snap_ask_qty  <= w_snap_ask_qty_nxt;
      r_valid         <= w_valid_nxt;
      r_side          <= w_side_nxt;
      r_price         <= w_price_nxt;
      r_qty           <= w_qty_nxt;
      r_busy          <= w_busy_nxt;
      r_order_count   <= w_order_count_nxt;
      r_reject_count  <= w_reject_count_nxt;
      r_crossed_count <= w_crossed_count_nxt;
      r_cool_cnt      <= w_cool_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt         = r_state;
    w_snap_bid_nxt      = r_snap_bid;
    w_snap_bid_qty_nxt  = r_snap_bid_qty;
    w_snap_ask_nxt      = r_snap_ask;
    w_snap_ask_qty_nxt  = r_snap_ask_qty;
    w_valid_nxt         = r_valid;
    w_side_nxt          = r_side;
    w_price_nxt         = r_price;
    w_qty_nxt           = r_qty;
    w_order_count_nxt   = r_order_count;
    w_reject_count_nxt  = r_reject_count;
    w_crossed_count_nxt = r_crossed_count;
    w_cool_cnt_nxt      = r_cool_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (tob_valid) begin
          w_snap_bid_nxt     = best_bid_price;
          w_snap_bid_qty_nxt = best_bid_qty;
          w_snap_ask_nxt     = best_ask_price;
          w_snap_ask_qty_nxt = best_ask_qty;
          w_state_nxt        = ST_EVAL;
        end
      end

      ST_EVAL: begin
        w_state_nxt = ST_IDLE;
        if (w_empty) begin
          w_reject_count_nxt = r_reject_count + CW'(1);
        end else if (w_crossed) begin
          w_crossed_count_nxt = r_crossed_count + CW'(1);
          w_reject_count_nxt  = r_reject_count + CW'(1);
        end else if (w_wide || (w_cap_qty == '0)) begin
          w_reject_count_nxt = r_reject_count + CW'(1);
        end else begin
          w_valid_nxt = 1'b1;
          w_side_nxt  = w_buy ? SW'(0) : SW'(1);
          w_price_nxt = w_buy ? r_snap_ask : r_snap_bid;
          w_qty_nxt   = w_cap_qty;
          w_state_nxt = ST_SEND;
        end
      end

      // The payload is held until the downstream accepts it
      ST_SEND: begin
        if (order_ready) begin
          w_valid_nxt       = 1'b0;
          w_order_count_nxt = r_order_count + CW'(1);
          if (COOLDOWN == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cool_cnt_nxt = COOLDOWN - TW'(1);
            w_state_nxt    = ST_COOL;
          end
        end
      end

      ST_COOL: begin
        if (r_cool_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cool_cnt_nxt = r_cool_cnt - TW'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy is registered alongside the state register
  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  assign order_valid   = r_valid;
  assign order_side    = r_side;
  assign order_price   = r_price;
  assign order_qty     = r_qty;
  assign busy          = r_busy;
  assign order_count   = r_order_count;
  assign reject_count  = r_reject_count;
  assign crossed_count = r_crossed_count;

endmodule

// File: tb/tb_tob_signal_engine.sv
// tb_tob_signal_engine: directed bench for tob_signal_engine.
// The bench drives inputs on the falling edge and checks outputs on the
// falling edge. It tracks the expected counter values locally.
module tb_tob_signal_engine;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] best_bid_price;
  logic [31:0] best_bid_qty;
  logic [31:0] best_ask_price;
  logic [31:0] best_ask_qty;
  logic        tob_valid;
  logic        order_ready;
  logic        order_valid;
  logic [7:0]  order_side;
  logic [31:0] order_price;
  logic [31:0] order_qty;
  logic        busy;
  logic [31:0] order_count;
  logic [31:0] reject_count;
  logic [31:0] crossed_count;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_oc  = '0;
  logic [31:0] exp_rej = '0;
  logic [31:0] exp_crs = '0;

  tob_signal_engine dut (
    .clk            (clk),
    .rstn           (rstn),
    .best_bid_price (best_bid_price),
    .best_bid_qty   (best_bid_qty),
    .best_ask_price (best_ask_price),
    .best_ask_qty   (best_ask_qty),
    .tob_valid      (tob_valid),
    .order_ready    (order_ready),
    .order_valid    (order_valid),
    .order_side     (order_side),
    .order_price    (order_price),
    .order_qty      (order_qty),
    .busy           (busy),
    .order_count    (order_count),
    .reject_count   (reject_count),
    .crossed_count  (crossed_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_tob(input logic [31:0] bp, input logic [31:0] bq,
                           input logic [31:0] ap, input logic [31:0] aq);
    best_bid_price = bp;
    best_bid_qty   = bq;
    best_ask_price = ap;
    best_ask_qty   = aq;
    tob_valid      = 1'b1;
  endtask

  // Garbage book values that must not leak into the snapshot or the payload
  task automatic scramble;
    tob_valid      = 1'b0;
    best_bid_price = 32'd7;
    best_bid_qty   = 32'd999;
    best_ask_price = 32'd8;
    best_ask_qty   = 32'd1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  // Full order with order_ready held low for 'hold' cycles in SEND
  task automatic run_order(input string tag,
                           input logic [31:0] bp, input logic [31:0] bq,
                           input logic [31:0] ap, input logic [31:0] aq,
                           input int hold, input logic [7:0] e_side,
                           input logic [31:0] e_price, input logic [31:0] e_qty);
    order_ready = 1'b0;
    drive_tob(bp, bq, ap, aq);
    @(negedge clk);
    scramble();
    check_eq({tag, "_eval_valid"}, 32'(order_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(order_valid), 32'd1);
    check_eq({tag, "_side"},  32'(order_side), 32'(e_side));
    check_eq({tag, "_price"}, order_price, e_price);
    check_eq({tag, "_qty"},   order_qty, e_qty);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(order_valid), 32'd1);
      check_eq({tag, "_hold_price"}, order_price, e_price);
      check_eq({tag, "_hold_qty"},   order_qty, e_qty);
    end
    order_ready = 1'b1;
    @(negedge clk);
    order_ready = 1'b0;
    exp_oc = exp_oc + 32'd1;
    check_eq({tag, "_drop"},  32'(order_valid), 32'd0);
    check_eq({tag, "_count"}, order_count, exp_oc);
    wait_idle({tag, "_idle"});
  endtask

  // Evaluation that must reject. order_ready is held high to show that it is ignored.
  task automatic run_reject(input string tag,
                            input logic [31:0] bp, input logic [31:0] bq,
                            input logic [31:0] ap, input logic [31:0] aq,
                            input logic crossed);
    order_ready = 1'b1;
    drive_tob(bp, bq, ap, aq);
    @(negedge clk);
    scramble();
    check_eq({tag, "_eval_valid"}, 32'(order_valid), 32'd0);
    @(negedge clk);
    order_ready = 1'b0;
    exp_rej = exp_rej + 32'd1;
    if (crossed) exp_crs = exp_crs + 32'd1;
    check_eq({tag, "_valid"},   32'(order_valid), 32'd0);
    check_eq({tag, "_busy"},    32'(busy), 32'd0);
    check_eq({tag, "_rej"},     reject_count, exp_rej);
    check_eq({tag, "_crossed"}, crossed_count, exp_crs);
    check_eq({tag, "_oc"},      order_count, exp_oc);
  endtask

  initial begin
    rstn        = 1'b0;
    order_ready = 1'b0;
    scramble();
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_valid", 32'(order_valid), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_side",  32'(order_side), 32'd0);
    check_eq("rst_price", order_price, 32'd0);
    check_eq("rst_qty",   order_qty, 32'd0);
    check_eq("rst_oc",    order_count, 32'd0);
    check_eq("rst_rej",   reject_count, 32'd0);
    check_eq("rst_crs",   crossed_count, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic buy: ready already high, 2-cycle latency, 4 cooldown cycles
    order_ready = 1'b1;
    drive_tob(32'd100, 32'd50, 32'd101, 32'd30);
    @(negedge clk);
    scramble();
    check_eq("buy_eval_busy",  32'(busy), 32'd1);
    check_eq("buy_eval_valid", 32'(order_valid), 32'd0);
    @(negedge clk);
    check_eq("buy_valid", 32'(order_valid), 32'd1);
    check_eq("buy_side",  32'(order_side), 32'd0);
    check_eq("buy_price", order_price, 32'd101);
    check_eq("buy_qty",   order_qty, 32'd30);
    check_eq("buy_busy",  32'(busy), 32'd1);
    @(negedge clk);
    exp_oc = 32'd1;
    check_eq("buy_drop",  32'(order_valid), 32'd0);
    check_eq("buy_count", order_count, exp_oc);
    check_eq("buy_cool0", 32'(busy), 32'd1);
    // tob_valid is ignored during cooldown
    best_bid_price = 32'd100;
    best_ask_price = 32'd101;
    tob_valid      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("buy_cool", 32'(busy), 32'd1);
    end
    tob_valid = 1'b0;
    @(negedge clk);
    check_eq("buy_cool_end", 32'(busy), 32'd0);
    check_eq("buy_no_reeval", order_count, exp_oc);
    order_ready = 1'b0;

    // Spread of exactly the threshold, qty capped by the thin side, payload held
    run_order("hold_buy",  32'd100, 32'd500, 32'd102, 32'd10,  5, 8'd0, 32'd102, 32'd10);
    run_order("hold_sell", 32'd100, 32'd10,  32'd102, 32'd500, 5, 8'd1, 32'd100, 32'd10);
    // MAX_QTY cap
    run_order("maxq",      32'd100, 32'd1000, 32'd101, 32'd800, 0, 8'd0, 32'd101, 32'd100);

    // Rejects
    run_reject("rej_bid0",    32'd0,   32'd10, 32'd101,       32'd10, 1'b0);
    run_reject("rej_askE",    32'd100, 32'd10, 32'hFFFF_FFFF, 32'd10, 1'b0);
    run_reject("rej_cross",   32'd105, 32'd10, 32'd103,       32'd10, 1'b1);
    run_reject("rej_lock",    32'd103, 32'd10, 32'd103,       32'd10, 1'b1);
    run_reject("rej_wide",    32'd100, 32'd10, 32'd110,       32'd10, 1'b0);
    run_reject("rej_wide3",   32'd100, 32'd10, 32'd103,       32'd10, 1'b0);
    run_reject("rej_qty0",    32'd100, 32'd0,  32'd101,       32'd5,  1'b0);

    // Reset while an order is pending
    order_ready = 1'b0;
    drive_tob(32'd100, 32'd50, 32'd101, 32'd30);
    @(negedge clk);
    scramble();
    @(negedge clk);
    check_eq("rsend_pre_valid", 32'(order_valid), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_eq("rsend_valid", 32'(order_valid), 32'd0);
    check_eq("rsend_busy",  32'(busy), 32'd0);
    check_eq("rsend_price", order_price, 32'd0);
    check_eq("rsend_qty",   order_qty, 32'd0);
    check_eq("rsend_oc",    order_count, 32'd0);
    check_eq("rsend_rej",   reject_count, 32'd0);
    check_eq("rsend_crs",   crossed_count, 32'd0);
    exp_oc  = '0;
    exp_rej = '0;
    exp_crs = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_order("post_rst", 32'd200, 32'd5, 32'd201, 32'd7, 1, 8'd1, 32'd200, 32'd5);

    // order_count wrap
    force dut.r_order_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_order_count;
    exp_oc = 32'hFFFF_FFFF;
    run_order("wrap", 32'd100, 32'd50, 32'd101, 32'd30, 0, 8'd0, 32'd101, 32'd30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
